// File: rtl/store_write_sequencer_pkg.sv
// ============================================================================
// Module      : store_write_sequencer_pkg
// Description : Shared encodings for the store write sequencer: store sizes,
//               write-data mux select values and the sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_write_sequencer_pkg;

    // Store size encodings (2'b11 is reserved and behaves as a word store)
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Memory write-data mux select values
    localparam logic WDSEL_B  = 1'b0;
    localparam logic WDSEL_WC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_MERGE = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Sub-word stores need a read-modify-write of the containing word
    function automatic logic is_rmw(input logic [1:0] size);
        return (size == SZ_HALF) || (size == SZ_BYTE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_write_sequencer_if.sv
// ============================================================================
// Module      : store_write_sequencer_if
// Description : Bundle of the store request, memory strobe and status signals
//               between the control FSM / data memory and the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_write_sequencer_if;

    logic        start;
    logic [1:0]  store_size;
    logic [1:0]  addr_lo;
    logic [31:0] b_data;
    logic [31:0] mem_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        write_data_ctrl;
    logic [31:0] wc_data;
    logic        busy;
    logic        done;
    logic        align_err;

    // Control FSM and data memory side
    modport master (
        output start, store_size, addr_lo, b_data, mem_rdata,
        input  mem_rd, mem_wr, write_data_ctrl, wc_data, busy, done, align_err
    );

    // Sequencer side
    modport slave (
        input  start, store_size, addr_lo, b_data, mem_rdata,
        output mem_rd, mem_wr, write_data_ctrl, wc_data, busy, done, align_err
    );

endinterface

`default_nettype wire

// File: rtl/store_lane_merge.sv
// ============================================================================
// Module      : store_lane_merge
// Description : Combinational lane merge. Inserts the low byte / halfword of
//               the store source into the addressed little-endian lane of the
//               word read from memory; all other bits come from the read word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_lane_merge
    import store_write_sequencer_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [15:0] bdata,
    input  wire logic [1:0]  size,
    input  wire logic [1:0]  lane,
    output logic      [31:0] merged
);

    // Overlay the store bytes onto the read word
    always_comb begin
        merged = rdata;
        if (size == SZ_BYTE) begin
            case (lane)
                2'd0:    merged[7:0]   = bdata[7:0];
                2'd1:    merged[15:8]  = bdata[7:0];
                2'd2:    merged[23:16] = bdata[7:0];
                default: merged[31:24] = bdata[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            // Only bit 1 selects the halfword; bit 0 is ignored here
            if (lane[1]) begin
                merged[31:16] = bdata;
            end else begin
                merged[15:0]  = bdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_write_sequencer.sv
// ============================================================================
// Module      : store_write_sequencer
// Description : Multi-cycle store sequencer. Word stores write B directly;
//               half/byte stores read the word, merge the store lane into WC
//               and write WC back. Optional macro STORE_ALIGN_CHECK_EN turns
//               misaligned half/word stores into an immediate align_err+done
//               with no memory access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_write_sequencer
    import store_write_sequencer_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  wire logic             clk,
    input  wire logic             reset,
    store_write_sequencer_if.slave bus
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t            r_state;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [15:0]       r_b;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_wdsel;
    logic [31:0]       r_wc;
    logic              r_busy;
    logic              r_done;
    logic              r_align_err;

    logic [31:0]       w_merged;
    logic              w_misaligned;
    logic              w_unused_b_hi;

    // The upper half of B only reaches memory through the external mux
    assign w_unused_b_hi = &{1'b0, bus.b_data[31:16]};

`ifdef STORE_ALIGN_CHECK_EN
    assign w_misaligned = ((bus.store_size == SZ_HALF) && bus.addr_lo[0]) ||
                          (!is_rmw(bus.store_size) && (bus.addr_lo != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    store_lane_merge u_merge (
        .rdata  (bus.mem_rdata),
        .bdata  (r_b),
        .size   (r_size),
        .lane   (r_lane),
        .merged (w_merged)
    );

    // Sequencer FSM with registered strobes, status and composed word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_size      <= SZ_WORD;
            r_lane      <= 2'b00;
            r_b         <= 16'h0000;
            r_wait_cnt  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_wdsel     <= WDSEL_B;
            r_wc        <= 32'h0000_0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_size <= bus.store_size;
                        r_lane <= bus.addr_lo;
                        r_b    <= bus.b_data[15:0];
                        r_busy <= 1'b1;
                        if (w_misaligned) begin
                            r_done      <= 1'b1;
                            r_align_err <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (is_rmw(bus.store_size)) begin
                            r_mem_rd <= 1'b1;
                            r_state  <= ST_READ;
                        end else begin
                            r_mem_wr <= 1'b1;
                            r_wdsel  <= WDSEL_B;
                            r_state  <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    r_mem_rd   <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_wait_cnt <= '0;
                        r_wdsel    <= WDSEL_WC;
                        r_state    <= ST_MERGE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_MERGE: begin
                    r_wc     <= w_merged;
                    r_mem_wr <= 1'b1;
                    r_state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_mem_wr <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_done      <= 1'b0;
                    r_align_err <= 1'b0;
                    r_busy      <= 1'b0;
                    r_wdsel     <= WDSEL_B;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_mem_rd    <= 1'b0;
                    r_mem_wr    <= 1'b0;
                    r_done      <= 1'b0;
                    r_align_err <= 1'b0;
                    r_busy      <= 1'b0;
                    r_wdsel     <= WDSEL_B;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd          = r_mem_rd;
    assign bus.mem_wr          = r_mem_wr;
    assign bus.write_data_ctrl = r_wdsel;
    assign bus.wc_data         = r_wc;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
`ifdef STORE_ALIGN_CHECK_EN
    assign bus.align_err       = r_align_err;
`else
    assign bus.align_err       = 1'b0 & r_align_err;
`endif

endmodule

`default_nettype wire
